l_outport_ctrl: RTL and testbench

Packet-lock and flow-control controller for the Local output port of the NoC router, directly downstream of the Local round-robin priority processor. Captures the one-hot winner among N/S/W/E, drives the crossbar select and input pop strobes for the whole packet, and meters flits against downstream credits. Pulses `rr_register_change_order_o` back to the processor at packet end so the round-robin order rotates.

---
 rtl/l_outport_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_l_outport_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l_outport_ctrl.sv
// l_outport_ctrl: packet lock and credit-based flow control for the Local
// output port. It latches the round-robin winner for a whole packet, drives
// the crossbar select and the input pop strobes, and meters flits against
// downstream credits.
module l_outport_ctrl #(
  parameter int CREDITS   = 4,
  parameter int MAX_FLITS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] rrp_l_priority_to_cs_i,
  input  logic       rrp_l_priority_n_i,
  input  logic       rrp_l_priority_s_i,
  input  logic       rrp_l_priority_w_i,
  input  logic       rrp_l_priority_e_i,
  input  logic       rrp_l_priority_l_i,
  input  logic       n_flit_valid_i,
  input  logic       s_flit_valid_i,
  input  logic       w_flit_valid_i,
  input  logic       e_flit_valid_i,
  input  logic       n_flit_tail_i,
  input  logic       s_flit_tail_i,
  input  logic       w_flit_tail_i,
  input  logic       e_flit_tail_i,
  input  logic       l_credit_return_i,
  output logic [2:0] cs_l_sel_o,
  output logic       n_pop_o,
  output logic       s_pop_o,
  output logic       w_pop_o,
  output logic       e_pop_o,
  output logic       l_out_valid_o,
  output logic       rr_register_change_order_o,
  output logic       l_busy_o,
  output logic       l_pkt_err_o
);

  localparam int FCW = $clog2(MAX_FLITS + 1);

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_N    = 3'b001;
  localparam logic [2:0] SEL_S    = 3'b010;
  localparam logic [2:0] SEL_W    = 3'b011;
  localparam logic [2:0] SEL_E    = 3'b100;

  localparam logic [3:0]     CREDIT_MAX = 4'(CREDITS);
  localparam logic [FCW-1:0] FLIT_MAX   = FCW'(MAX_FLITS);
  localparam logic [FCW-1:0] FLIT_ONE   = FCW'(1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t         state_q, state_d;
  logic [2:0]     sel_q, sel_d;
  logic [3:0]     credit_q, credit_d;
  logic [FCW-1:0] flit_q, flit_d;
  logic           change_q, change_d;
  logic           err_q, err_d;

  logic [3:0]     onehot;
  logic [2:0]     onehot_code;
  logic           grant_ok;
  logic           sel_valid;
  logic           sel_tail;
  logic           transfer;
  logic [FCW-1:0] flit_inc;
  logic           flit_limit;
  logic           release_pkt;

  assign onehot = {rrp_l_priority_e_i, rrp_l_priority_w_i,
                   rrp_l_priority_s_i, rrp_l_priority_n_i};

  // Translate the one-hot winner into the code it is expected to carry
  always_comb begin
    onehot_code = SEL_NONE;
    case (onehot)
      4'b0001: onehot_code = SEL_N;
      4'b0010: onehot_code = SEL_S;
      4'b0100: onehot_code = SEL_W;
      4'b1000: onehot_code = SEL_E;
      default: onehot_code = SEL_NONE;
    endcase
  end

  // A grant is trusted only if code and one-hot agree, L is clear, and the
  // round-robin order is not being rotated this cycle (that grant is stale)
  assign grant_ok = $onehot(onehot) && !rrp_l_priority_l_i &&
                    (rrp_l_priority_to_cs_i == onehot_code) && !change_q;

  // Route the head-of-FIFO status of the locked input
  always_comb begin
    sel_valid = 1'b0;
    sel_tail  = 1'b0;
    case (sel_q)
      SEL_N: begin sel_valid = n_flit_valid_i; sel_tail = n_flit_tail_i; end
      SEL_S: begin sel_valid = s_flit_valid_i; sel_tail = s_flit_tail_i; end
      SEL_W: begin sel_valid = w_flit_valid_i; sel_tail = w_flit_tail_i; end
      SEL_E: begin sel_valid = e_flit_valid_i; sel_tail = e_flit_tail_i; end
      default: begin sel_valid = 1'b0; sel_tail = 1'b0; end
    endcase
  end

  assign transfer    = (state_q == LOCKED) && sel_valid && (credit_q != 4'd0);
  assign flit_inc    = flit_q + FLIT_ONE;
  assign flit_limit  = (flit_inc == FLIT_MAX);
  assign release_pkt = transfer && (sel_tail || flit_limit);

  // Lock/release sequencing, flit counting and the forced-release error flag
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    flit_d   = flit_q;
    err_d    = err_q;
    change_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_ok) begin
          state_d = LOCKED;
          sel_d   = rrp_l_priority_to_cs_i;
          flit_d  = '0;
        end
      end
      LOCKED: begin
        if (transfer) begin
          flit_d = flit_inc;
        end
        if (release_pkt) begin
          state_d  = IDLE;
          sel_d    = SEL_NONE;
          change_d = 1'b1;
          if (!sel_tail) begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = SEL_NONE;
      end
    endcase
  end

  // Credit bookkeeping: a simultaneous send and return cancel, returns saturate
  always_comb begin
    credit_d = credit_q;
    if (transfer && !l_credit_return_i) begin
      credit_d = credit_q - 4'd1;
    end else if (!transfer && l_credit_return_i && (credit_q != CREDIT_MAX)) begin
      credit_d = credit_q + 4'd1;
    end
  end

  // Steer the pop strobe to the locked input only on a real transfer
  always_comb begin
    n_pop_o = 1'b0;
    s_pop_o = 1'b0;
    w_pop_o = 1'b0;
    e_pop_o = 1'b0;
    if (transfer) begin
      case (sel_q)
        SEL_N:   n_pop_o = 1'b1;
        SEL_S:   s_pop_o = 1'b1;
        SEL_W:   w_pop_o = 1'b1;
        SEL_E:   e_pop_o = 1'b1;
        default: n_pop_o = 1'b0;
      endcase
    end
  end

  // State and bookkeeping registers; reset drops any lock without a rotate pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sel_q    <= SEL_NONE;
      credit_q <= CREDIT_MAX;
      flit_q   <= '0;
      change_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      credit_q <= credit_d;
      flit_q   <= flit_d;
      change_q <= change_d;
      err_q    <= err_d;
    end
  end

  assign cs_l_sel_o                 = sel_q;
  assign l_out_valid_o              = transfer;
  assign rr_register_change_order_o = change_q;
  assign l_busy_o                   = (state_q == LOCKED);
  assign l_pkt_err_o                = err_q;

endmodule

// File: tb/tb_l_outport_ctrl.sv
// Testbench for l_outport_ctrl: directed packet scenarios followed by random
// traffic, checked by a scoreboard fed from a packet-level reference model.
module tb_l_outport_ctrl;

  localparam int CREDITS   = 4;
  localparam int MAX_FLITS = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] code_in;
  logic       pri_n, pri_s, pri_w, pri_e, pri_l;
  logic       val_n, val_s, val_w, val_e;
  logic       tail_n, tail_s, tail_w, tail_e;
  logic       credit_ret;
  logic [2:0] cs_l_sel_o;
  logic       n_pop_o, s_pop_o, w_pop_o, e_pop_o;
  logic       l_out_valid_o, rr_register_change_order_o, l_busy_o, l_pkt_err_o;

  always #5 clk = ~clk;

  l_outport_ctrl #(.CREDITS(CREDITS), .MAX_FLITS(MAX_FLITS)) dut (
    .clk                        (clk),
    .reset                      (reset),
    .rrp_l_priority_to_cs_i     (code_in),
    .rrp_l_priority_n_i         (pri_n),
    .rrp_l_priority_s_i         (pri_s),
    .rrp_l_priority_w_i         (pri_w),
    .rrp_l_priority_e_i         (pri_e),
    .rrp_l_priority_l_i         (pri_l),
    .n_flit_valid_i             (val_n),
    .s_flit_valid_i             (val_s),
    .w_flit_valid_i             (val_w),
    .e_flit_valid_i             (val_e),
    .n_flit_tail_i              (tail_n),
    .s_flit_tail_i              (tail_s),
    .w_flit_tail_i              (tail_w),
    .e_flit_tail_i              (tail_e),
    .l_credit_return_i          (credit_ret),
    .cs_l_sel_o                 (cs_l_sel_o),
    .n_pop_o                    (n_pop_o),
    .s_pop_o                    (s_pop_o),
    .w_pop_o                    (w_pop_o),
    .e_pop_o                    (e_pop_o),
    .l_out_valid_o              (l_out_valid_o),
    .rr_register_change_order_o (rr_register_change_order_o),
    .l_busy_o                   (l_busy_o),
    .l_pkt_err_o                (l_pkt_err_o)
  );

  typedef struct {
    int         cyc;
    logic [3:0] pops;
    logic [2:0] sel;
    logic       busy;
    logic       co;
    logic       err;
  } exp_t;

  exp_t expQ[$];
  int   checks  = 0;
  int   errors  = 0;
  int   cycleNo = 0;

  // Packet-level reference state (port index 0..3 = N,S,W,E)
  bit   mLocked;
  bit   mCo;
  bit   mErr;
  int   mPort;
  int   mCredits;
  int   mCount;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycleNo);
    end
  endtask

  function automatic int grantPort(input logic [2:0] code, input logic [4:0] oh);
    if (oh[4]) return -1;
    if ($countones(oh[3:0]) != 1) return -1;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) return (int'(code) == i + 1) ? i : -1;
    end
    return -1;
  endfunction

  function automatic void modelReset();
    mLocked  = 1'b0;
    mCo      = 1'b0;
    mErr     = 1'b0;
    mPort    = 0;
    mCredits = CREDITS;
    mCount   = 0;
  endfunction

  // Drive one cycle of inputs and advance the reference model by one cycle
  task automatic applyStimulus(input logic [2:0] code, input logic [4:0] oh,
                               input logic [3:0] valid, input logic [3:0] tail,
                               input logic ret);
    exp_t e;
    bit   xfer;
    bit   rel;
    int   gp;
    @(negedge clk);
    code_in = code;
    {pri_l, pri_e, pri_w, pri_s, pri_n} = oh;
    {val_e, val_w, val_s, val_n} = valid;
    {tail_e, tail_w, tail_s, tail_n} = tail;
    credit_ret = ret;
    cycleNo++;

    e.cyc  = cycleNo;
    e.busy = mLocked;
    e.sel  = mLocked ? 3'(mPort + 1) : 3'b000;
    e.co   = mCo;
    e.err  = mErr;
    xfer   = mLocked && valid[mPort] && (mCredits > 0);
    e.pops = xfer ? 4'(1 << mPort) : 4'b0000;
    if (xfer || mCo) expQ.push_back(e);

    rel = 1'b0;
    if (mLocked) begin
      if (xfer) begin
        mCount++;
        if (tail[mPort]) rel = 1'b1;
        else if (mCount == MAX_FLITS) begin
          rel  = 1'b1;
          mErr = 1'b1;
        end
      end
      if (rel) mLocked = 1'b0;
    end else begin
      gp = grantPort(code, oh);
      if (!mCo && gp >= 0) begin
        mLocked = 1'b1;
        mPort   = gp;
        mCount  = 0;
      end
    end
    mCredits = mCredits - int'(xfer) + int'(ret);
    if (mCredits > CREDITS) mCredits = CREDITS;
    mCo = rel;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_sel"},   int'(cs_l_sel_o), 0);
    checkOutput({tag, "_pops"},  int'({e_pop_o, w_pop_o, s_pop_o, n_pop_o}), 0);
    checkOutput({tag, "_valid"}, int'(l_out_valid_o), 0);
    checkOutput({tag, "_co"},    int'(rr_register_change_order_o), 0);
    checkOutput({tag, "_busy"},  int'(l_busy_o), 0);
    checkOutput({tag, "_err"},   int'(l_pkt_err_o), 0);
  endtask

  // Assert reset mid-cycle (inputs left as they are), check outputs, release
  task automatic doReset(input string tag);
    #3;
    reset = 1'b1;
    #1;
    checkIdle(tag);
    repeat (2) @(negedge clk);
    code_in = 3'b000;
    {pri_l, pri_e, pri_w, pri_s, pri_n} = 5'b0;
    {val_e, val_w, val_s, val_n} = 4'b0;
    {tail_e, tail_w, tail_s, tail_n} = 4'b0;
    credit_ret = 1'b0;
    #3;
    reset = 1'b0;
    modelReset();
  endtask

  // Monitor: whenever the DUT shows a flit or a rotate pulse, match it to the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && (l_out_valid_o || rr_register_change_order_o)) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_event: valid=%0b co=%0b pops=%b sel=%0d, expected none (cycle %0d)",
                   l_out_valid_o, rr_register_change_order_o,
                   {e_pop_o, w_pop_o, s_pop_o, n_pop_o}, cs_l_sel_o, cycleNo);
        end else begin
          e = expQ.pop_front();
          checkOutput("event_cycle", cycleNo, e.cyc);
          checkOutput("pops",  int'({e_pop_o, w_pop_o, s_pop_o, n_pop_o}), int'(e.pops));
          checkOutput("valid", int'(l_out_valid_o), int'(|e.pops));
          checkOutput("sel",   int'(cs_l_sel_o), int'(e.sel));
          checkOutput("busy",  int'(l_busy_o), int'(e.busy));
          checkOutput("change_order", int'(rr_register_change_order_o), int'(e.co));
          checkOutput("pkt_err", int'(l_pkt_err_o), int'(e.err));
        end
      end
    end
  end

  initial begin
    logic [2:0] rc;
    logic [4:0] roh;
    logic [3:0] rv, rt;
    logic       rr;
    int         g, p;

    reset = 1'b0;
    code_in = 3'b000;
    {pri_l, pri_e, pri_w, pri_s, pri_n} = 5'b0;
    {val_e, val_w, val_s, val_n} = 4'b0;
    {tail_e, tail_w, tail_s, tail_n} = 4'b0;
    credit_ret = 1'b0;
    modelReset();

    @(negedge clk);
    doReset("reset");

    // N grant, three-flit packet with full credits
    applyStimulus(3'b001, 5'b00001, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(3'b000, 5'b00000, 4'b0001, 4'b0000, 1'b0);
    applyStimulus(3'b000, 5'b00000, 4'b0001, 4'b0000, 1'b0);
    applyStimulus(3'b000, 5'b00000, 4'b0001, 4'b0001, 1'b0);
    applyStimulus(3'b000, 5'b00000, 4'b0000, 4'b0000, 1'b0);

    // W packet with one credit left: stall, single returns, send+return together
    applyStimulus(3'b011, 5'b00100, 4'b0000, 4'b0000, 1'b0);
    repeat (3) applyStimulus(3'b000, 5'b00000, 4'b0100, 4'b0000, 1'b0);
    applyStimulus(3'b000, 5'b00000, 4'b0100, 4'b0000, 1'b1);
    applyStimulus(3'b000, 5'b00000, 4'b0100, 4'b0000, 1'b0);
    applyStimulus(3'b000, 5'b00000, 4'b0100, 4'b0000, 1'b0);
    applyStimulus(3'b000, 5'b00000, 4'b0000, 4'b0000, 1'b1);
    applyStimulus(3'b000, 5'b00000, 4'b0100, 4'b0100, 1'b1);
    repeat (5) applyStimulus(3'b000, 5'b00000, 4'b0000, 4'b0000, 1'b1);

    // Single-flit E packet, then a stale grant during the rotate cycle
    applyStimulus(3'b100, 5'b01000, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(3'b000, 5'b00000, 4'b1000, 4'b1000, 1'b0);
    applyStimulus(3'b001, 5'b00001, 4'b1111, 4'b0000, 1'b0);
    applyStimulus(3'b000, 5'b00000, 4'b1111, 4'b0000, 1'b1);

    // Malformed grants must all be ignored
    applyStimulus(3'b010, 5'b00001, 4'b1111, 4'b0000, 1'b0);
    applyStimulus(3'b001, 5'b00011, 4'b1111, 4'b0000, 1'b0);
    applyStimulus(3'b101, 5'b10000, 4'b1111, 4'b0000, 1'b0);
    applyStimulus(3'b001, 5'b10001, 4'b1111, 4'b0000, 1'b0);
    applyStimulus(3'b000, 5'b00000, 4'b1111, 4'b0000, 1'b0);
    applyStimulus(3'b000, 5'b00000, 4'b1111, 4'b0000, 1'b0);

    // E packet without a tail: forced release after MAX_FLITS transfers
    applyStimulus(3'b100, 5'b01000, 4'b0000, 4'b0000, 1'b1);
    repeat (6) applyStimulus(3'b000, 5'b00000, 4'b1000, 4'b0000, 1'b1);

    // Clean S packet afterwards: error flag stays set
    applyStimulus(3'b010, 5'b00010, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(3'b000, 5'b00000, 4'b0010, 4'b0000, 1'b1);
    applyStimulus(3'b000, 5'b00000, 4'b0010, 4'b0010, 1'b1);
    applyStimulus(3'b000, 5'b00000, 4'b0000, 4'b0000, 1'b1);

    // Reset during the second flit of an S packet
    applyStimulus(3'b010, 5'b00010, 4'b0000, 4'b0000, 1'b1);
    applyStimulus(3'b000, 5'b00000, 4'b0010, 4'b0000, 1'b1);
    applyStimulus(3'b000, 5'b00000, 4'b0010, 4'b0000, 1'b1);
    doReset("midreset");

    // N packet locks normally after reset
    applyStimulus(3'b001, 5'b00001, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(3'b000, 5'b00000, 4'b0001, 4'b0000, 1'b0);
    applyStimulus(3'b000, 5'b00000, 4'b0001, 4'b0001, 1'b0);
    applyStimulus(3'b000, 5'b00000, 4'b0000, 4'b0000, 1'b0);

    // Random traffic with a mix of good and malformed grants
    repeat (600) begin
      g = $urandom_range(0, 9);
      p = $urandom_range(0, 3);
      case (g)
        5:       begin rc = 3'(((p + 1) % 4) + 1); roh = 5'(1 << p); end
        6:       begin rc = 3'(p + 1); roh = 5'((1 << p) | (1 << ((p + 1) % 4))); end
        7:       begin rc = 3'b101; roh = 5'b10000; end
        8:       begin rc = 3'(p + 1); roh = 5'((1 << p) | 16); end
        9:       begin rc = 3'b000; roh = 5'b00000; end
        default: begin rc = 3'(p + 1); roh = 5'(1 << p); end
      endcase
      for (int i = 0; i < 4; i++) begin
        rv[i] = ($urandom_range(0, 9) < 7);
        rt[i] = ($urandom_range(0, 9) < 3);
      end
      rr = ($urandom_range(0, 9) < 4);
      applyStimulus(rc, roh, rv, rt, rr);
    end

    repeat (4) applyStimulus(3'b000, 5'b00000, 4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    #3;

    checkOutput("scoreboard_drained", expQ.size(), 0);
    while (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      $display("[TB] FAIL missing_event: expected event in cycle %0d pops=%b co=%0b, got none",
               e.cyc, e.pops, e.co);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
